// File: rtl/fetch_pc_unit_if.sv
// Control/data bundle between the main FSM, memory/ALU result buses and the fetch/PC unit.
// The master side drives strobes, buses and ALU flags. The slave side returns PC/IR state.
interface fetch_pc_unit_if;
  logic        pc_update;
  logic [1:0]  branch;
  logic        ir_write;
  logic [31:0] result;
  logic [31:0] read_data;
  logic        alu_zero;
  logic        alu_neg;
  logic        alu_ovf;
  logic        alu_carry;

  logic [31:0] pc;
  logic [31:0] old_pc;
  logic [31:0] instr;
  logic [6:0]  op;
  logic [31:0] data_reg;
  logic        pc_write;
  logic        branch_taken;
  logic        misaligned;

  modport master (
    output pc_update, branch, ir_write, result, read_data,
           alu_zero, alu_neg, alu_ovf, alu_carry,
    input  pc, old_pc, instr, op, data_reg, pc_write, branch_taken, misaligned
  );

  modport slave (
    input  pc_update, branch, ir_write, result, read_data,
           alu_zero, alu_neg, alu_ovf, alu_carry,
    output pc, old_pc, instr, op, data_reg, pc_write, branch_taken, misaligned
  );
endinterface

// File: rtl/fetch_pc_unit.sv
// PC, OldPC, IR and data register for the multicycle RV32I core.
// Also resolves conditional branches from the ALU flags and the IR's funct3.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic           clk,
  input  logic           reset,
  fetch_pc_unit_if.slave bus
);

  typedef enum logic [2:0] {
    F3_BEQ  = 3'b000,
    F3_BNE  = 3'b001,
    F3_BLT  = 3'b100,
    F3_BGE  = 3'b101,
    F3_BLTU = 3'b110,
    F3_BGEU = 3'b111
  } funct3_e;

  localparam logic [1:0] BRANCH_COND = 2'b10;

  logic [31:0] pc_q, pc_d;
  logic [31:0] old_pc_q, old_pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] data_reg_q, data_reg_d;
  logic        misaligned_q, misaligned_d;

  logic [2:0]  funct3;
  logic        signed_lt;
  logic        cond;
  logic        branch_taken;
  logic        pc_write;
  logic        target_aligned;

  // funct3 always comes from the latched IR, so read_data never reaches an output.
  assign funct3    = instr_q[14:12];
  assign signed_lt = bus.alu_neg ^ bus.alu_ovf;

  // NOTE: every signal written in an always_comb gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    cond = 1'b0;
    case (funct3)
      F3_BEQ:  cond = bus.alu_zero;
      F3_BNE:  cond = !bus.alu_zero;
      F3_BLT:  cond = signed_lt;
      F3_BGE:  cond = !signed_lt;
      F3_BLTU: cond = !bus.alu_carry;
      F3_BGEU: cond = bus.alu_carry;
      default: cond = 1'b0;
    endcase
  end

  assign branch_taken   = (bus.branch == BRANCH_COND) && cond;
  assign pc_write       = bus.pc_update || branch_taken;
  assign target_aligned = (bus.result[1:0] == 2'b00);

  always_comb begin
    pc_d         = pc_q;
    old_pc_d     = old_pc_q;
    instr_d      = instr_q;
    misaligned_d = misaligned_q;
    data_reg_d   = bus.read_data;

    // A misaligned target leaves the PC alone and only sets the sticky flag.
    if (pc_write) begin
      if (target_aligned) pc_d = bus.result;
      else                misaligned_d = 1'b1;
    end

    // old_pc captures the PC before any write in the same cycle.
    if (bus.ir_write) begin
      instr_d  = bus.read_data;
      old_pc_d = pc_q;
    end
  end

  // NOTE: state registers use non-blocking assignments so that every flop samples values
  // from before the edge, regardless of process ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q         <= RESET_PC;
      old_pc_q     <= RESET_PC;
      instr_q      <= NOP_INSTR;
      data_reg_q   <= 32'h0000_0000;
      misaligned_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      old_pc_q     <= old_pc_d;
      instr_q      <= instr_d;
      data_reg_q   <= data_reg_d;
      misaligned_q <= misaligned_d;
    end
  end

  assign bus.pc           = pc_q;
  assign bus.old_pc       = old_pc_q;
  assign bus.instr        = instr_q;
  assign bus.op           = instr_q[6:0];
  assign bus.data_reg     = data_reg_q;
  assign bus.pc_write     = pc_write;
  assign bus.branch_taken = branch_taken;
  assign bus.misaligned   = misaligned_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit. A behavioural model derives branch outcomes from the
// operand values, and every negedge compares the DUT against it. Literal checks pin the model.
module tb_fetch_pc_unit;
  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  fetch_pc_unit_if bus ();

  fetch_pc_unit #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Model state, plus the operand values that the ALU flags were derived from.
  logic [31:0] m_pc, m_old, m_instr, m_data, m_rs1, m_rs2;
  logic        m_mis;
  bit          m_valid = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic cond_of(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'b000:  return a == b;
      3'b001:  return a != b;
      3'b100:  return $signed(a) <  $signed(b);
      3'b101:  return $signed(a) >= $signed(b);
      3'b110:  return a <  b;
      3'b111:  return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic exp_taken();
    return (bus.branch == 2'b10) && cond_of(m_instr[14:12], m_rs1, m_rs2);
  endfunction

  function automatic logic exp_pc_write();
    return bus.pc_update || exp_taken();
  endfunction

  // Model update at each rising edge.
  always @(posedge clk) begin
    if (reset) begin
      m_pc    <= RST_PC;
      m_old   <= RST_PC;
      m_instr <= NOP;
      m_data  <= 32'h0;
      m_mis   <= 1'b0;
      m_valid <= 1'b1;
    end else if (m_valid) begin
      if (exp_pc_write()) begin
        if (bus.result % 4 == 0) m_pc  <= bus.result;
        else                     m_mis <= 1'b1;
      end
      if (bus.ir_write) begin
        m_instr <= bus.read_data;
        m_old   <= m_pc;
      end
      m_data <= bus.read_data;
    end
  end

  // Compare process: the DUT against the model on every negedge once reset has been seen.
  always @(negedge clk) begin
    if (m_valid) begin
      check("pc",           bus.pc,                   m_pc);
      check("old_pc",       bus.old_pc,               m_old);
      check("instr",        bus.instr,                m_instr);
      check("op",           {25'h0, bus.op},          {25'h0, m_instr[6:0]});
      check("data_reg",     bus.data_reg,             m_data);
      check("misaligned",   {31'h0, bus.misaligned},  {31'h0, m_mis});
      check("branch_taken", {31'h0, bus.branch_taken}, {31'h0, exp_taken()});
      check("pc_write",     {31'h0, bus.pc_write},    {31'h0, exp_pc_write()});
    end
  end

  // Drives the ALU flags that subtracting b from a would produce.
  task automatic set_ops(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, ~b} + 33'd1;
    m_rs1 = a;
    m_rs2 = b;
    bus.alu_zero  = (s[31:0] == 32'h0);
    bus.alu_neg   = s[31];
    bus.alu_ovf   = (a[31] != b[31]) && (s[31] != a[31]);
    bus.alu_carry = s[32];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.pc_update = 1'b0;
    bus.ir_write  = 1'b0;
    bus.branch    = 2'b00;
  endtask

  // Loads a new instruction into the IR without moving the PC.
  task automatic load_ir(input logic [31:0] ins);
    idle();
    bus.read_data = ins;
    bus.ir_write  = 1'b1;
    tick();
    idle();
  endtask

  // One branch-evaluation cycle; checks branch_taken and the resulting PC literally.
  task automatic do_branch(input string name, input logic [31:0] tgt, input logic exp_bt,
                           input logic [31:0] exp_pc);
    bus.branch = 2'b10;
    bus.result = tgt;
    #1;
    check({name, "_taken"}, {31'h0, bus.branch_taken}, {31'h0, exp_bt});
    tick();
    idle();
    check({name, "_pc"}, bus.pc, exp_pc);
  endtask

  initial begin
    reset         = 1'b1;
    bus.pc_update = 1'b1;
    bus.ir_write  = 1'b1;
    bus.branch    = 2'b10;
    bus.result    = 32'h0000_0200;
    bus.read_data = 32'hdead_beef;
    set_ops(32'd0, 32'd0);
    m_rs1 = 32'd0;
    tick();
    tick();
    reset = 1'b0;
    idle();
    bus.read_data = 32'h0;

    // Reset values win over the active strobes.
    check("rst_pc",    bus.pc,              32'h100);
    check("rst_old",   bus.old_pc,          32'h100);
    check("rst_instr", bus.instr,           32'h13);
    check("rst_op",    {25'h0, bus.op},     32'h13);
    check("rst_mis",   {31'h0, bus.misaligned}, 32'h0);

    // The fetch cycle: IR load and PC increment in the same cycle.
    bus.read_data = 32'h0050_0093;
    bus.result    = 32'h0000_0104;
    bus.ir_write  = 1'b1;
    bus.pc_update = 1'b1;
    tick();
    idle();
    check("fetch_instr", bus.instr,    32'h0050_0093);
    check("fetch_old",   bus.old_pc,   32'h100);
    check("fetch_pc",    bus.pc,       32'h104);
    check("fetch_data",  bus.data_reg, 32'h0050_0093);

    // beq taken, then not taken.
    load_ir(32'h0020_8463);
    check("beq_old", bus.old_pc, 32'h104);
    bus.read_data = 32'h0020_f463;  // a bgeu is on the bus but not latched
    set_ops(32'd5, 32'd5);
    do_branch("beq_t", 32'h108, 1'b1, 32'h108);
    set_ops(32'd5, 32'd6);
    do_branch("beq_nt", 32'h10c, 1'b0, 32'h108);

    // rs1=-1, rs2=1: the signed and unsigned compares disagree.
    set_ops(32'hffff_ffff, 32'd1);
    load_ir(32'h0020_c463);
    do_branch("blt", 32'h110, 1'b1, 32'h110);
    load_ir(32'h0020_e463);
    do_branch("bltu", 32'h114, 1'b0, 32'h110);
    load_ir(32'h0020_f463);
    do_branch("bgeu", 32'h118, 1'b1, 32'h118);
    load_ir(32'h0020_d463);
    do_branch("bge", 32'h11c, 1'b0, 32'h118);
    load_ir(32'h0020_9463);
    do_branch("bne", 32'h120, 1'b1, 32'h120);
    load_ir(32'h0020_a463);
    do_branch("f3_010", 32'h124, 1'b0, 32'h120);

    // Other branch encodings never take a branch, even when the condition holds.
    load_ir(32'h0020_9463);
    for (int i = 0; i < 4; i++) begin
      if (i != 2) begin
        bus.branch = 2'(i);
        bus.result = 32'h200;
        #1;
        check("branch_enc", {31'h0, bus.branch_taken}, 32'h0);
        tick();
        idle();
      end
    end
    check("branch_enc_pc", bus.pc, 32'h120);

    // A misaligned target holds the PC, and the flag stays set.
    bus.pc_update = 1'b1;
    bus.result    = 32'h0000_0106;
    tick();
    idle();
    check("mis_pc",  bus.pc,                 32'h120);
    check("mis_set", {31'h0, bus.misaligned}, 32'h1);
    bus.pc_update = 1'b1;
    bus.result    = 32'h0000_0200;
    tick();
    idle();
    check("mis_pc2",    bus.pc,                 32'h200);
    check("mis_sticky", {31'h0, bus.misaligned}, 32'h1);
    set_ops(32'd3, 32'd7);
    do_branch("mis_br", 32'h203, 1'b1, 32'h200);

    // Reset mid-instruction, with strobes active.
    reset         = 1'b1;
    bus.ir_write  = 1'b1;
    bus.pc_update = 1'b1;
    bus.result    = 32'h300;
    bus.read_data = 32'h1234_5678;
    tick();
    reset = 1'b0;
    idle();
    check("rst2_pc",    bus.pc,                 32'h100);
    check("rst2_instr", bus.instr,              32'h13);
    check("rst2_old",   bus.old_pc,             32'h100);
    check("rst2_data",  bus.data_reg,           32'h0);
    check("rst2_mis",   {31'h0, bus.misaligned}, 32'h0);

    // data_reg follows read_data with one cycle of latency.
    for (int i = 0; i < 6; i++) begin
      logic [31:0] v;
      v = 32'hA5A5_0000 + 32'(i * 32'h1111);
      bus.read_data = v;
      tick();
      check("data_lat", bus.data_reg, v);
    end

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Instruction-side state holder for the multicycle RV32I core; sits between unified memory/ALU result bus and the main control FSM.
- Owns PC, OldPC, instruction register (IR) and data register; supplies op field to the FSM.
- Consumes the FSM's PCUpdate/Branch/IRWrite strobes; resolves all six conditional branch types from ALU flags and funct3.
- Flags misaligned PC targets.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, IR value on reset (addi x0,x0,0).

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- pc_update  in  1  unconditional PC write strobe (PCUpdate from FSM).
- branch  in  2  2'b10 = conditional branch evaluation; 2'b00/2'b01/2'b11 = no branch.
- ir_write  in  1  latch instruction and OldPC (IRWrite from FSM).
- result  in  32  Result bus; candidate next PC.
- read_data  in  32  memory read data.
- alu_zero  in  1  ALU result == 0 (rs1-rs2).
- alu_neg  in  1  ALU result bit 31.
- alu_ovf  in  1  signed overflow of rs1-rs2.
- alu_carry  in  1  carry-out of rs1+~rs2+1 (1 = rs1 >= rs2 unsigned).
- pc  out  32  current PC register.
- old_pc  out  32  PC of instruction held in IR.
- instr  out  32  instruction register.
- op  out  7  instr[6:0], to FSM.
- data_reg  out  32  registered read_data.
- pc_write  out  1  combinational effective PC write enable.
- branch_taken  out  1  combinational branch condition result.
- misaligned  out  1  sticky misaligned-target flag.

Behaviour:
- Reset (sync, reset=1 at posedge): pc=RESET_PC, old_pc=RESET_PC, instr=NOP_INSTR, data_reg=0, misaligned=0. Reset overrides every strobe in the same cycle. Reset asserted mid-instruction discards all in-flight state.
- Branch condition (combinational, funct3=instr[14:12]):
  - 000 beq: alu_zero.
  - 001 bne: !alu_zero.
  - 100 blt: alu_neg^alu_ovf.
  - 101 bge: !(alu_neg^alu_ovf).
  - 110 bltu: !alu_carry.
  - 111 bgeu: alu_carry.
  - 010/011: 0.
- branch_taken = (branch==2'b10) & condition.
- pc_write = pc_update | branch_taken.
- PC update:
  - On pc_write with result[1:0]==0: pc<=result, 1-cycle latency.
  - On pc_write with result[1:0]!=0: pc holds, misaligned<=1. The flag stays set until reset and has no other effect on the datapath.
- IR update:
  - On ir_write: instr<=read_data, old_pc<=pc (value before any same-cycle PC write).
  - Simultaneous ir_write and pc_write (fetch state) is legal: old_pc gets the pre-increment pc, pc gets result.
- data_reg <= read_data every cycle (no enable); valid the cycle after the memory read.
- op = instr[6:0] continuously; changes only the cycle after ir_write.
- funct3 is sampled from the current IR, never from read_data.
- No combinational path from read_data to any output.

Test Plan:
- Reset with RESET_PC=32'h100 -> pc=0x100, old_pc=0x100, instr=0x00000013, op=0x13, misaligned=0.
- Fetch cycle: read_data=0x00500093, result=0x104, ir_write=1, pc_update=1 at pc=0x100 -> next cycle instr=0x00500093, old_pc=0x100, pc=0x104.
- beq (instr=0x00208463), branch=2'b10, alu_zero=1, result=0x108 -> branch_taken=1, pc=0x108. Repeat with alu_zero=0 -> pc unchanged.
- blt/bltu: rs1=-1, rs2=1 (alu_neg=1, alu_ovf=0, alu_carry=1) -> blt taken, bltu not taken, bgeu taken.
- pc_update=1, result=0x00000106 -> pc holds. misaligned=1 and stays 1 across later valid updates until reset.
- reset asserted together with ir_write=1, pc_update=1 -> reset values win. data_reg equals the read_data from the previous cycle at each posedge after release.
